// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack channel plus the valid/ready
// channel towards decode/control, with its jump/branch/zero feedback.
interface instruction_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic        instr_ready;
   logic        jump;
   logic        branch;
   logic        zero;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        halted;

   modport master (
      output imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus4, halted,
      input  imem_rdata, imem_ack, instr_ready, jump, branch, zero
   );

   modport slave (
      input  imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus4, halted,
      output imem_rdata, imem_ack, instr_ready, jump, branch, zero
   );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, reads instruction memory over req/ack and hands
// the captured word to decode over valid/ready; stops for good after retiring HALT.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
   input logic                 clk,
   input logic                 rst_n,
   instruction_fetch_if.master bus
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {StFetch, StIssue, StHalt} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        req_q;
   logic        valid_q;
   logic        halted_q;

   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic [31:0] branch_offset;
   logic [31:0] next_pc;
   logic        fetch_done;
   logic        retire;
   logic        is_halt;

   assign pc_plus4      = pc_q + 32'd4;
   assign jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
   assign branch_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign is_halt       = (instr_q[31:26] == HALT_OPCODE);

   // Jump has priority over a taken branch.
   always_comb begin
      next_pc = pc_plus4;
      if (bus.jump) begin
         next_pc = jump_target;
      end else if (bus.branch && bus.zero) begin
         next_pc = pc_plus4 + branch_offset;
      end
   end

   // Ack only counts while a request is actually on the bus.
   assign fetch_done = (state_q == StFetch) && req_q && bus.imem_ack;
   assign retire     = (state_q == StIssue) && bus.instr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StFetch;
         pc_q     <= RESET_PC_ALIGNED;
         instr_q  <= 32'h0;
         req_q    <= 1'b0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            StFetch: begin
               // First edge after reset release raises the request.
               req_q <= 1'b1;
               if (fetch_done) begin
                  instr_q <= bus.imem_rdata;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= StIssue;
               end
            end
            StIssue: begin
               if (retire) begin
                  valid_q <= 1'b0;
                  if (is_halt) begin
                     halted_q <= 1'b1;
                     state_q  <= StHalt;
                  end else begin
                     pc_q    <= next_pc;
                     req_q   <= 1'b1;
                     state_q <= StFetch;
                  end
               end
            end
            StHalt: begin
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
            default: begin
               req_q   <= 1'b0;
               valid_q <= 1'b0;
               state_q <= StFetch;
            end
         endcase
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.opcode      = instr_q[31:26];
   assign bus.instr_valid = valid_q;
   assign bus.pc          = pc_q;
   assign bus.pc_plus4    = pc_plus4;
   assign bus.halted      = halted_q;

`ifndef SYNTHESIS
   pc_aligned_a : assert property (@(posedge clk) disable iff (!rst_n) pc_q[1:0] == 2'b00);

   req_valid_excl_a : assert property (@(posedge clk) disable iff (!rst_n)
      !(req_q && valid_q));

   req_hold_a : assert property (@(posedge clk) disable iff (!rst_n)
      (req_q && !bus.imem_ack) |=> (req_q && $stable(pc_q)));

   halt_sticky_a : assert property (@(posedge clk) disable iff (!rst_n)
      halted_q |=> (halted_q && !req_q && !valid_q));
`endif

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the MIPS processor, directly upstream of the control unit. Holds the program counter, requests instruction words from instruction memory over a req/ack handshake, and presents the captured instruction and its opcode to decode/control with a valid/ready handshake. On retirement it computes the next PC from the jump, branch and zero feedback. It stops fetching permanently after retiring HALT (opcode 6'b111111).

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] ignored, forced 0)
- HALT_OPCODE, 6'b111111, opcode that terminates fetch

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction-memory read request
- imem_addr  out  32  byte address of the request, always equal to pc
- imem_rdata  in  32  instruction word, valid on a cycle with imem_ack=1
- imem_ack  in  1  read completed; sampled only while imem_req=1
- instr  out  32  captured instruction register
- opcode  out  6  instr[31:26], feeds the control unit
- instr_valid  out  1  instr/opcode/pc are valid for the downstream stage
- instr_ready  in  1  downstream has consumed the instruction and jump/branch/zero are valid this cycle
- jump  in  1  from control unit
- branch  in  1  from control unit
- zero  in  1  ALU zero flag
- pc  out  32  address of the instruction in instr
- pc_plus4  out  32  pc + 4, combinational, wraps mod 2^32
- halted  out  1  HALT retired; fetch stopped

## Operation
- States: FETCH, ISSUE, HALT.
- FETCH: imem_req=1 and imem_addr=pc. On a clock edge with imem_ack=1, instr<=imem_rdata and the state moves to ISSUE. While ack=0, req and addr stay stable.
- ISSUE: imem_req=0 and instr_valid=1. instr and pc stay stable until retire. Retire is a clock edge with instr_ready=1.
- On retire of a non-HALT instruction: pc<=next_pc and the state moves to FETCH.
- On retire when opcode==HALT_OPCODE: pc is unchanged, the state moves to HALT and halted<=1.
- HALT: imem_req=0, instr_valid=0, halted=1. It is left only by reset. All inputs are ignored.
- next_pc priority:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else branch&zero: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), 32-bit add, carry discarded.
  - else pc_plus4.
- pc[1:0] is always 00.
- imem_ack with imem_req=0 is ignored. instr_ready outside ISSUE is ignored.
- jump and branch both set: jump wins.

## Timing
- Reset (async assert, sync to clk deassert):
  - pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, halted=0.
  - imem_req=0 while rst_n=0, and imem_req=1 from the first clock after release.
- Reset mid-operation (any state): all outputs return to reset values immediately. An in-flight ack is discarded.
- Latency:
  - Ack in the first FETCH cycle: instr_valid rises on the next edge.
  - instr_ready in the first ISSUE cycle: FETCH resumes one edge later.
  - Minimum 2 cycles per instruction. Memory wait states add 1 cycle each.
- instr_valid falls on the edge after retire. A new instruction is never valid in the cycle following retire.
- halted rises on the retire edge of HALT and stays high.
- pc_plus4 at pc=32'hFFFF_FFFC is 32'h0000_0000.

## Test plan
- Reset and sequential fetch: RESET_PC=0, memory acks same cycle, instr_ready tied 1, three ADD words → imem_addr 0,4,8 in consecutive FETCH cycles, instr_valid every 2nd cycle, pc=8 on the third valid.
- Wait states: ack delayed 3 cycles → imem_req and imem_addr held stable for 4 cycles, instr captured only on the ack edge, instr_valid low until then.
- Jump, BEQ taken and BEQ not taken:
  - Jump: pc=32'h0000_0040, instr=32'h0800_0010, jump=1 at retire → next imem_addr 32'h0000_0040.
  - BEQ taken: pc=0x100, imm=16'hFFFE, branch=1, zero=1 → next 0x0FC.
  - BEQ not taken: same with zero=0 → next 0x104.
- Backpressure: hold instr_ready=0 for 5 cycles in ISSUE → instr, pc and instr_valid unchanged, imem_req=0. Retire on the 6th cycle → fetch resumes.
- HALT: instruction 32'hFC00_0000 retired → halted=1 on that edge, no further imem_req for 20 cycles, pc unchanged, acks ignored.
- Async reset mid-wait: drop rst_n between clock edges during FETCH with ack pending → imem_req=0 and pc=RESET_PC immediately. After release, fetch restarts at RESET_PC.
